regbank_writer: RTL and testbench

REGBANK_WRITER -- requirements
Module: regbank_writer

---
 rtl/regbank_writer_if.sv | 33 +++
 rtl/regbank_writer.sv | 120 ++++++++++++
 tb/tb_regbank_writer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_writer_if.sv
// Result channels (ALU, load) and register bank write port of regbank_writer.
// The DUT connects through the slave modport, the producer side through master.
interface regbank_writer_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_reg;
  logic [31:0] alu_data;

  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_reg;
  logic [31:0] ld_data;

  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable;
  logic [15:0] pending_mask;
  logic        busy;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output ld_valid, ld_reg, ld_data,
    input  alu_ready, ld_ready,
    input  write_reg, write_data, write_enable, pending_mask, busy
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  ld_valid, ld_reg, ld_data,
    output alu_ready, ld_ready,
    output write_reg, write_data, write_enable, pending_mask, busy
  );
endinterface

// File: rtl/regbank_writer.sv
// Arbitrates ALU and load results into an in-order write queue and replays each entry
// to an edge-latching register bank as a SETUP/PULSE pair. Optional: WB_ZERO_REG_DISCARD_EN.
module regbank_writer #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  regbank_writer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE} state_t;

  typedef struct packed {
    logic [3:0]  rg;
    logic [31:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             not_full_q;
  logic             prefer_ld;
  state_t           state;

  logic   alu_gnt;
  logic   ld_gnt;
  logic   alu_hs;
  logic   ld_hs;
  logic   push;
  logic   pop;
  entry_t push_entry;
  logic [15:0] pend;

  // A lone valid always wins; contention goes to the channel not served last.
  assign alu_gnt = bus.alu_valid && (!bus.ld_valid || !prefer_ld);
  assign ld_gnt  = bus.ld_valid && (!bus.alu_valid || prefer_ld);

  assign bus.alu_ready = not_full_q && alu_gnt;
  assign bus.ld_ready  = not_full_q && ld_gnt;

  assign alu_hs = bus.alu_valid && bus.alu_ready;
  assign ld_hs  = bus.ld_valid && bus.ld_ready;

  assign push_entry = ld_hs ? entry_t'{rg: bus.ld_reg, data: bus.ld_data}
                            : entry_t'{rg: bus.alu_reg, data: bus.alu_data};

`ifdef WB_ZERO_REG_DISCARD_EN
  assign push = (alu_hs || ld_hs) && (push_entry.rg != 4'd0);
`else
  assign push = alu_hs || ld_hs;
`endif

  assign pop = (count != '0) && ((state == IDLE) || (state == PULSE));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  // NOTE: queue storage has no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: reset is synchronous (sampled at the edge) and all state uses non-blocking updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      not_full_q       <= 1'b0;
      prefer_ld        <= 1'b1;
      bus.write_reg    <= '0;
      bus.write_data   <= '0;
      bus.write_enable <= 1'b0;
    end else begin
      count      <= count_next;
      not_full_q <= (count_next != CNT_W'(DEPTH));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (alu_hs || ld_hs) prefer_ld <= alu_hs;
      if (pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        bus.write_reg  <= mem[rd_ptr].rg;
        bus.write_data <= mem[rd_ptr].data;
      end
      // SETUP presents address/data a full cycle ahead of the latching edge.
      case (state)
        IDLE:  if (pop) state <= SETUP;
        SETUP: begin
          state            <= PULSE;
          bus.write_enable <= 1'b1;
        end
        PULSE: begin
          bus.write_enable <= 1'b0;
          state            <= pop ? SETUP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight entry is the one held on write_reg while SETUP or PULSE.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) pend[mem[rd_ptr + PTR_W'(i)].rg] = 1'b1;
    end
    if (state != IDLE) pend[bus.write_reg] = 1'b1;
  end

  assign bus.pending_mask = pend;
  assign bus.busy         = (count != '0) || (state != IDLE);
endmodule

// File: tb/tb_regbank_writer.sv
// Scoreboard bench for regbank_writer: drivers push expected bank writes on handshake,
// a negedge monitor pops and compares on every write_enable pulse.
module tb_regbank_writer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbank_writer_if bus ();
  regbank_writer #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]  rg;
    logic [31:0] data;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         sb[$];
  bit          grant_log[$];
  logic [31:0] bank [16];
  logic        prev_we   = 1'b0;
  logic [3:0]  prev_reg  = '0;
  logic [31:0] prev_data = '0;
  wr_t         mon_exp;
  bit          mon_ok;
  logic [9:0]  rdy_seen;
  int          k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each pulse must match the oldest accepted write and follow a stable SETUP cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we = 1'b0;
    end else begin
      if (bus.write_enable) begin
        check("we_not_adjacent", prev_we, 0);
        mon_ok = (sb.size() != 0);
        check("write_expected", mon_ok, 1);
        if (mon_ok) begin
          mon_exp = sb.pop_front();
          check("write_reg", bus.write_reg, mon_exp.rg);
          check("write_data", bus.write_data, mon_exp.data);
          check("setup_reg", prev_reg, mon_exp.rg);
          check("setup_data", prev_data, mon_exp.data);
          bank[bus.write_reg] = bus.write_data;
        end
      end
      prev_we   = bus.write_enable;
      prev_reg  = bus.write_reg;
      prev_data = bus.write_data;
    end
  end

  task automatic send(input bit is_ld, input logic [3:0] r, input logic [31:0] d,
                      input bit expect_write);
    bit hs = 1'b0;
    for (int t = 0; t < 64 && !hs; t++) begin
      @(negedge clk);
      if (is_ld) begin
        bus.ld_valid = 1'b1; bus.ld_reg = r; bus.ld_data = d;
      end else begin
        bus.alu_valid = 1'b1; bus.alu_reg = r; bus.alu_data = d;
      end
      #1;
      hs = is_ld ? bus.ld_ready : bus.alu_ready;
      @(posedge clk);
    end
    if (is_ld) check("ld_handshake", hs, 1);
    else       check("alu_handshake", hs, 1);
    if (hs) begin
      grant_log.push_back(is_ld);
      if (expect_write) sb.push_back('{rg: r, data: d});
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(negedge clk);
      #1;
      idle = !bus.busy;
    end
    check("drain_idle", idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) bank[i] = '0;
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_reg  = '0; bus.ld_data  = '0;

    // Reset state, with both valids up so ready is really exercised.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.alu_valid = 1'b1;
    bus.ld_valid  = 1'b1;
    #1;
    check("rst_we", bus.write_enable, 0);
    check("rst_reg", bus.write_reg, 0);
    check("rst_data", bus.write_data, 0);
    check("rst_pend", bus.pending_mask, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_alu_ready", bus.alu_ready, 0);
    check("rst_ld_ready", bus.ld_ready, 0);
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    rst_n = 1'b1;

    // Single write: SETUP one cycle after the handshake, PULSE the next.
    send(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk); bus.ld_valid = 1'b0; #1;
    check("lat_c0_we", bus.write_enable, 0);
    check("lat_c0_pend", bus.pending_mask, 32'h0008);
    check("lat_c0_busy", bus.busy, 1);
    @(negedge clk); #1;
    check("lat_setup_we", bus.write_enable, 0);
    check("lat_setup_reg", bus.write_reg, 3);
    check("lat_setup_data", bus.write_data, 32'hDEAD_BEEF);
    check("lat_setup_pend", bus.pending_mask, 32'h0008);
    @(negedge clk); #1;
    check("lat_pulse_we", bus.write_enable, 1);
    check("lat_pulse_pend", bus.pending_mask, 32'h0008);
    @(negedge clk); #1;
    check("lat_after_we", bus.write_enable, 0);
    check("lat_after_pend", bus.pending_mask, 0);
    check("lat_after_busy", bus.busy, 0);
    check("lat_bank3", bank[3], 32'hDEAD_BEEF);

    // WAW on reg 7: handshakes at E0 (alu) and E2 (ld); pulses at E2 and E4.
    send(1'b0, 4'd7, 32'd1, 1'b1);
    @(negedge clk); bus.alu_valid = 1'b0;
    send(1'b1, 4'd7, 32'd2, 1'b1);
    @(negedge clk); bus.ld_valid = 1'b0; #1;
    check("waw_pend_a", bus.pending_mask[7], 1);
    @(negedge clk); #1;
    check("waw_pend_b", bus.pending_mask[7], 1);
    @(negedge clk); #1;
    check("waw_pend_c", bus.pending_mask[7], 1);
    @(negedge clk); #1;
    check("waw_pend_clear", bus.pending_mask[7], 0);
    wait_idle();
    check("waw_bank7", bank[7], 32'd2);

    // Register 0 handling.
`ifdef WB_ZERO_REG_DISCARD_EN
    send(1'b0, 4'd0, 32'h55, 1'b0);
    @(negedge clk); bus.alu_valid = 1'b0; #1;
    check("zero_pend", bus.pending_mask, 0);
    check("zero_busy", bus.busy, 0);
    repeat (4) @(negedge clk);
    #1;
    check("zero_busy_later", bus.busy, 0);
    check("zero_bank0", bank[0], 0);
`else
    send(1'b0, 4'd0, 32'h55, 1'b1);
    @(negedge clk); bus.alu_valid = 1'b0; #1;
    check("zero_pend", bus.pending_mask, 32'h0001);
    check("zero_busy", bus.busy, 1);
    wait_idle();
    check("zero_bank0", bank[0], 32'h55);
`endif

    // Full queue: alu_valid held 10 cycles while the FSM drains one entry per 2 cycles.
    // Occupancy reaches 4 at edge 6 and edge 8, so ready is low in cycles 7 and 9.
    wait_idle();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.alu_valid = 1'b1;
      bus.alu_reg   = 4'(k + 1);
      bus.alu_data  = 32'hA000_0000 + k;
      #1;
      rdy_seen[c] = bus.alu_ready;
      @(posedge clk);
      if (rdy_seen[c]) begin
        sb.push_back('{rg: 4'(k + 1), data: 32'hA000_0000 + k});
        k++;
      end
    end
    @(negedge clk); bus.alu_valid = 1'b0;
    check("full_ready_pattern", rdy_seen, 10'b01_0111_1111);
    check("full_accepts", k, 8);
    wait_idle();
    check("full_sb_empty", sb.size(), 0);
    check("full_bank8", bank[8], 32'hA000_0007);

    // Reset during PULSE of the first of three queued entries.
    send(1'b0, 4'd1, 32'h11, 1'b1);
    send(1'b0, 4'd2, 32'h22, 1'b1);
    send(1'b0, 4'd4, 32'h44, 1'b1);
    @(negedge clk); #1;
    check("mid_in_pulse", bus.write_enable, 1);
    check("mid_pulse_reg", bus.write_reg, 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_we", bus.write_enable, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_pend", bus.pending_mask, 0);
    check("mid_rst_ready", bus.alu_ready, 0);
    check("mid_sb_left", sb.size(), 2);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_first", bus.alu_ready, 0);
    @(negedge clk); #1;
    check("rel_ready_second", bus.alu_ready, 1);
    bus.alu_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("rel_busy", bus.busy, 0);
    check("rel_pend", bus.pending_mask, 0);
    check("rel_we", bus.write_enable, 0);

    // Contention: round-robin from ld after reset.
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) send(1'b1, 4'(9 + i), 32'hB000_0000 + i, 1'b1);
      for (int j = 0; j < 4; j++) send(1'b0, 4'(5 + j), 32'hC000_0000 + j, 1'b1);
    join
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    check("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      check("rr_grant", grant_log[i], (i % 2 == 0) ? 1 : 0);
    end
    wait_idle();
    check("rr_bank5", bank[5], 32'hC000_0000);
    check("rr_bank12", bank[12], 32'hB000_0003);

    check("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
